fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the single-cycle RISC-V core. Holds the PC, fetches 32-bit words over a req/ack instruction-memory port, registers the instruction and pre-decodes its opcode into the 3-bit immediate-format select. Presents `{pc, instr, imm_src}` to the decode/immediate-extension stage through a valid/ready handshake. Branch and jump redirects from execute retarget the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  single-cycle acknowledge; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  fetched word.
- `redirect_valid`  in  1  PC redirect strobe.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `out_valid`  out  1  output bundle valid.
- `out_ready`  in  1  downstream accepts.
- `out_pc`  out  32  PC of `out_instr`.
- `out_instr`  out  32  registered instruction; downstream uses [31:7].
- `out_imm_src`  out  3  0=I, 1=S, 2=B, 3=U, 4=J.
- `out_illegal`  out  1  opcode is not in the supported set.

## Operation
- States: IDLE, REQ, HOLD, DRAIN. Reset state is IDLE.
- `imem_req` = (state==REQ || state==DRAIN). `imem_addr` = `pc` in REQ and `drain_addr` in DRAIN.
- IDLE: always goes to REQ on the next edge.
- REQ: on `imem_ack`, load `imem_rdata` into the instruction register, latch `out_pc`=`pc`, set `out_valid`, and go to HOLD.
- HOLD: `out_valid`=1 and all outputs stay stable. On `out_ready`: `pc`<=`pc`+4 (wraps modulo 2^32), clear `out_valid`, go to REQ.
- Redirect has priority over everything else in every state:
  - IDLE: `pc`<=target; go to REQ.
  - HOLD: `pc`<=target; clear `out_valid`; go to REQ. If `out_ready` is high in the same cycle, the transfer still counts, but +4 is not applied.
  - REQ with `imem_ack` in the same cycle: discard the fetched word; `pc`<=target; go to REQ.
  - REQ without `imem_ack`: `drain_addr`<=`pc`; `pc`<=target; go to DRAIN.
  - DRAIN: keep requesting `drain_addr`. A further redirect only updates `pc`. On `imem_ack`, discard the word and go to REQ.
- `out_valid` is never set from a DRAIN acknowledge.
- Pre-decode on `imem_rdata[6:0]`, registered together with the instruction:
  - 0000011, 0010011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - 0110011 → 0, not illegal.
  - Anything else → 0, `out_illegal`=1.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `out_valid`=0, `out_pc`=`RESET_PC`, `out_instr`=0, `out_imm_src`=0, `out_illegal`=0, `pc`=`RESET_PC`.
- First `imem_req` is asserted on the first edge after `rst` is released.
- Latency: from the `imem_ack` edge, `out_valid` rises 1 cycle later.
- Throughput: with zero-wait memory and `out_ready` held at 1, one instruction every 2 cycles.
- From the `redirect_valid` edge:
  - Outside DRAIN, the request to the new target appears 1 cycle later.
  - In DRAIN, it appears 1 cycle after the pending ack.
- Asserting `rst` in any state returns immediately to the reset values. Any outstanding memory acknowledge is the memory's responsibility to cancel.
- Inputs are sampled on the rising edge of `clk` only.

## Test plan
- **Reset/boot:** `RESET_PC`=0x100; release `rst`; ack 1 cycle later with 0x00500093 → `out_valid`, `out_pc`=0x100, `out_imm_src`=0, `out_illegal`=0.
- **Streaming:** `out_ready`=1, ack every cycle the request is up, words sw/beq/lui/jal → `out_imm_src` 1,2,3,4 at PCs 0x100/104/108/10C, one every 2 cycles.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in HOLD → outputs stable and `imem_req`=0; `out_ready`=1 → next `imem_addr`=`pc`+4.
- **Redirect while outstanding:** redirect to 0x203 in REQ with no ack, ack 3 cycles later → `imem_addr` stays on the old address until the ack, that word is dropped, next request is to 0x200.
- **Redirect coincident with events:**
  - redirect with ack in the same REQ cycle → word discarded, next request to the target;
  - redirect with `out_ready` in HOLD → next request to the target, not `pc`+4.
- **Illegal opcode and wrap:** fetch 0xFFFFFFFF → `out_illegal`=1; PC 0xFFFFFFFC accepted → next `imem_addr`=0x00000000.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, req/ack instruction fetch, instruction register
// with opcode pre-decode to the immediate format, valid/ready output bundle.
// Ports:
//   clk, rst                      clock, async active-high reset
//   imem_req/addr/ack/rdata       instruction memory port
//   redirect_valid/redirect_pc    branch/jump retarget from execute
//   out_valid/out_ready           output handshake
//   out_pc/instr/imm_src/illegal  output bundle
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [2:0]  out_imm_src,
  output logic        out_illegal
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] drain_addr, drain_d;
  logic [31:0] tgt;
  logic        cap;
  logic        vld_d;
  logic [2:0]  src_d;
  logic        ill_d;

  assign tgt       = {redirect_pc[31:2], 2'b00};
  assign imem_req  = (state == REQ) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  always_comb begin
    src_d = 3'd0;
    ill_d = 1'b0;
    unique case (imem_rdata[6:0])
      7'b0000011,
      7'b0010011,
      7'b1100111,
      7'b1110011: src_d = 3'd0;
      7'b0100011: src_d = 3'd1;
      7'b1100011: src_d = 3'd2;
      7'b0110111,
      7'b0010111: src_d = 3'd3;
      7'b1101111: src_d = 3'd4;
      7'b0110011: src_d = 3'd0;
      default:    ill_d = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    drain_d = drain_addr;
    vld_d   = out_valid;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) pc_d = tgt;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d = tgt;
          // a request still in flight must be drained
          if (!imem_ack) begin
            drain_d = pc;
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          cap     = 1'b1;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          vld_d   = 1'b0;
          state_d = REQ;
        end else if (out_ready) begin
          pc_d    = pc + 32'd4;
          vld_d   = 1'b0;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_d = tgt;
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      drain_addr  <= RESET_PC;
      out_valid   <= 1'b0;
      out_pc      <= RESET_PC;
      out_instr   <= 32'd0;
      out_imm_src <= 3'd0;
      out_illegal <= 1'b0;
    end else begin
      pc         <= pc_d;
      drain_addr <= drain_d;
      out_valid  <= vld_d;
      if (cap) begin
        out_pc      <= pc;
        out_instr   <= imem_rdata;
        out_imm_src <= src_d;
        out_illegal <= ill_d;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed sequences, opcode table and random traffic for
// fetch_unit, checked every cycle against a transaction-level model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  out_imm_src;
  logic        out_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .out_imm_src(out_imm_src),
    .out_illegal(out_illegal)
  );

  // model: boot cycle pending, bundle held, stale request outstanding
  bit          m_boot;
  bit          m_held;
  bit          m_stale;
  logic [31:0] m_pc;
  logic [31:0] m_stale_addr;
  logic [31:0] m_opc;
  logic [31:0] m_ins;
  logic [2:0]  m_src;
  logic        m_ill;

  typedef struct {
    logic [31:0] w;
    logic [2:0]  src;
    logic        ill;
  } vec_t;

  vec_t tbl[14];

  logic [6:0] ops[12] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                          7'h37, 7'h17, 7'h6f, 7'h33, 7'h7f, 7'h00};

  function automatic logic [3:0] ref_dec(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    if (op == 7'h03 || op == 7'h13 || op == 7'h67 || op == 7'h73)
      return 4'h0;
    if (op == 7'h23) return 4'h1;
    if (op == 7'h63) return 4'h2;
    if (op == 7'h37 || op == 7'h17) return 4'h3;
    if (op == 7'h6f) return 4'h4;
    if (op == 7'h33) return 4'h0;
    return 4'h8;
  endfunction

  function automatic logic m_req();
    return !m_boot && !m_held;
  endfunction

  task automatic model_reset();
    m_boot       = 1'b1;
    m_held       = 1'b0;
    m_stale      = 1'b0;
    m_pc         = RST_PC;
    m_stale_addr = RST_PC;
    m_opc        = RST_PC;
    m_ins        = 32'd0;
    m_src        = 3'd0;
    m_ill        = 1'b0;
  endtask

  task automatic model_edge(input logic ack, input logic ready,
                            input logic rv, input logic [31:0] rpc,
                            input logic [31:0] rdata);
    logic [31:0] t;
    logic [3:0]  d;
    t = {rpc[31:2], 2'b00};
    if (m_boot) begin
      m_boot = 1'b0;
      if (rv) m_pc = t;
    end else if (m_held) begin
      if (rv) begin
        m_pc   = t;
        m_held = 1'b0;
      end else if (ready) begin
        m_pc   = m_pc + 32'd4;
        m_held = 1'b0;
      end
    end else if (m_stale) begin
      if (rv) m_pc = t;
      if (ack) m_stale = 1'b0;
    end else if (rv) begin
      if (!ack) begin
        m_stale      = 1'b1;
        m_stale_addr = m_pc;
      end
      m_pc = t;
    end else if (ack) begin
      d      = ref_dec(rdata);
      m_held = 1'b1;
      m_opc  = m_pc;
      m_ins  = rdata;
      m_src  = d[2:0];
      m_ill  = d[3];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string name);
    logic [101:0] act, exp;
    act = {imem_req, imem_addr, out_valid, out_pc,
           out_instr, out_imm_src, out_illegal};
    exp = {m_req(), (m_stale ? m_stale_addr : m_pc), m_held, m_opc,
           m_ins, m_src, m_ill};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic ack, input logic ready, input logic rv,
                      input logic [31:0] rpc, input logic [31:0] rdata);
    imem_ack       = ack;
    out_ready      = ready;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rdata     = rdata;
    @(posedge clk);
    model_edge(ack, ready, rv, rpc, rdata);
    @(negedge clk);
    chk_model("cycle");
  endtask

  task automatic ack_word(input logic [31:0] w);
    step(1'b1, 1'b0, 1'b0, 32'd0, w);
  endtask

  task automatic accept();
    step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  logic [31:0] words[4] = '{32'h00112023, 32'h00000063,
                            32'h000010b7, 32'h0000006f};
  logic [31:0] got_pc[$];
  logic [2:0]  got_src[$];
  int          got_at[$];

  initial begin
    int k;
    logic [31:0] r;
    logic [31:0] w;
    tbl[0]  = '{32'h00002083, 3'd0, 1'b0};
    tbl[1]  = '{32'h00500093, 3'd0, 1'b0};
    tbl[2]  = '{32'h000080e7, 3'd0, 1'b0};
    tbl[3]  = '{32'h00000073, 3'd0, 1'b0};
    tbl[4]  = '{32'h00112023, 3'd1, 1'b0};
    tbl[5]  = '{32'h00208463, 3'd2, 1'b0};
    tbl[6]  = '{32'h123450b7, 3'd3, 1'b0};
    tbl[7]  = '{32'h00001097, 3'd3, 1'b0};
    tbl[8]  = '{32'h0100006f, 3'd4, 1'b0};
    tbl[9]  = '{32'h002081b3, 3'd0, 1'b0};
    tbl[10] = '{32'hffffffff, 3'd0, 1'b1};
    tbl[11] = '{32'h00000000, 3'd0, 1'b1};
    tbl[12] = '{32'h0000000f, 3'd0, 1'b1};
    tbl[13] = '{32'h00000057, 3'd0, 1'b1};

    rst            = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_model("reset");
    chk("reset_addr", imem_addr, RST_PC);
    rst = 1'b0;

    // boot
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_addr", imem_addr, 32'h100);
    ack_word(32'h00500093);
    chk("boot_valid", 32'(out_valid), 32'd1);
    chk("boot_pc", out_pc, 32'h100);
    chk("boot_src", 32'(out_imm_src), 32'd0);
    chk("boot_ill", 32'(out_illegal), 32'd0);

    // asynchronous reset while holding a bundle
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_instr", out_instr, 32'd0);
    model_reset();
    @(negedge clk);
    chk_model("in_reset");
    rst = 1'b0;

    // streaming, zero-wait memory, ready held high
    k = 0;
    for (int i = 0; i < 8; i++) begin
      logic a;
      a = m_req();
      step(a, 1'b1, 1'b0, 32'd0, words[k % 4]);
      if (a) k++;
      if (out_valid) begin
        got_pc.push_back(out_pc);
        got_src.push_back(out_imm_src);
        got_at.push_back(i);
      end
    end
    chk("stream_count", got_pc.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
      chk("stream_pc", got_pc[i], 32'h100 + 32'(4 * i));
      chk("stream_src", 32'(got_src[i]), 32'(i + 1));
      chk("stream_slot", got_at[i], 32'(2 * i + 1));
    end

    // backpressure in HOLD
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      chk("bp_pc", out_pc, 32'h10c);
      chk("bp_instr", out_instr, 32'h0000006f);
      chk("bp_req", 32'(imem_req), 32'd0);
    end
    accept();
    chk("bp_next_addr", imem_addr, 32'h110);

    // redirect while a request is outstanding
    step(1'b0, 1'b0, 1'b1, 32'h203, 32'd0);
    chk("drain_addr0", imem_addr, 32'h110);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("drain_addr1", imem_addr, 32'h110);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("drain_addr2", imem_addr, 32'h110);
    ack_word(32'h00112023);
    chk("drain_drop", 32'(out_valid), 32'd0);
    chk("drain_tgt", imem_addr, 32'h200);
    chk("drain_req", 32'(imem_req), 32'd1);

    // redirect coincident with ack in REQ
    step(1'b1, 1'b0, 1'b1, 32'h300, 32'h00000063);
    chk("rq_ack_drop", 32'(out_valid), 32'd0);
    chk("rq_ack_tgt", imem_addr, 32'h300);

    // redirect coincident with out_ready in HOLD
    ack_word(32'h00000013);
    chk("hold_pc", out_pc, 32'h300);
    step(1'b0, 1'b1, 1'b1, 32'h400, 32'd0);
    chk("hold_rdr_addr", imem_addr, 32'h400);
    chk("hold_rdr_valid", 32'(out_valid), 32'd0);

    // illegal opcode and PC wrap
    ack_word(32'hffffffff);
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_src", 32'(out_imm_src), 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'hfffffffe, 32'd0);
    chk("wrap_tgt", imem_addr, 32'hfffffffc);
    ack_word(32'h00000013);
    chk("wrap_pc", out_pc, 32'hfffffffc);
    accept();
    chk("wrap_addr", imem_addr, 32'h00000000);

    // pre-decode table
    foreach (tbl[i]) begin
      ack_word(tbl[i].w);
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_src", 32'(out_imm_src), 32'(tbl[i].src));
      chk("tbl_ill", 32'(out_illegal), 32'(tbl[i].ill));
      accept();
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic a, rdy, rv;
      a   = m_req() && ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 1) == 1);
      rv  = ($urandom_range(0, 7) == 0);
      r   = $urandom;
      if ($urandom_range(0, 3) == 0) w = $urandom;
      else w = {r[31:7], ops[$urandom_range(0, 11)]};
      step(a, rdy, rv, $urandom, w);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk_model("rnd_reset");
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
